mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter for the core memory handshake (read/write, addr, wdata, wstrb, addr_ready out; rdata, data_ready back).
- Shares one memory port between the rv core (master 0) and a DMA/debug agent (master 1).
- Round-robin grant; the granted request is latched; one transaction is in flight at a time.
- Sits between the requesters and the memory/bus model.

Parameters:
- TIMEOUT_CYCLES, 255: max BUSY cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- m0_read, m1_read  in  1  read request
- m0_write, m1_write  in  1  write request
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  write data, already lane-shifted
- m0_wstrb, m1_wstrb  in  4  byte strobes
- m0_addr_ready, m1_addr_ready  in  1  request valid
- m0_rdata, m1_rdata  out  32  registered read data
- m0_data_ready, m1_data_ready  out  1  one-cycle completion pulse
- m0_err, m1_err  out  1  abort flag, qualified by data_ready
- s_read  out  1  latched read
- s_write  out  1  latched write
- s_addr  out  32  latched address
- s_wdata  out  32  latched write data
- s_wstrb  out  4  latched strobes
- s_addr_ready  out  1  request valid to slave
- s_rdata  in  32  slave read data
- s_data_ready  in  1  slave completion

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, last_grant=1 so master 0 wins first; any in-flight transfer is dropped with no completion pulse.
- States: IDLE, BUSY. All outputs are registered.
- Eligibility in IDLE: master i is eligible if mi_addr_ready=1, mi_read|mi_write=1, and mi_data_ready=0 this cycle. The completing master's stale request is ignored for that cycle.
- Arbitration in IDLE:
  - One eligible master: grant it.
  - Both eligible: grant the one not equal to last_grant.
  - On grant, latch addr/wdata/wstrb/read/write into s_* and set s_addr_ready=1.
  - Next state BUSY; last_grant <= grant.
- Read/write conflict: if both read and write are set, the transfer is a write (s_read=0).
- BUSY:
  - s_* are held constant and master inputs are ignored (a master dropping its request mid-transfer has no effect).
  - On s_data_ready=1: capture s_rdata into the granted mi_rdata (write: capture 0), then pulse mi_data_ready=1, mi_err=0 on the next cycle.
  - Also on that edge: clear s_addr_ready, s_read, s_write; return to IDLE.
- Latency:
  - Request visible on s_* 1 cycle after grant-eligible.
  - mi_data_ready arrives 1 cycle after s_data_ready.
  - At least 1 IDLE cycle between back-to-back transfers.
- s_data_ready while IDLE: ignored.
- mi_rdata holds its value until the next completion for that master.
- The non-granted master sees no pulses.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro:
  - A BUSY cycle counter (width $clog2(TIMEOUT_CYCLES+1)) clears on grant and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with s_data_ready=0: deassert s_*, return to IDLE, then pulse mi_data_ready=1, mi_err=1, mi_rdata=0.
  - If s_data_ready and expiry fall on the same cycle, the normal completion wins (err=0).
  - A late s_data_ready arriving in IDLE is ignored.
- Without the macro: no counter; BUSY waits indefinitely; m0_err and m1_err are tied 0.

Test Plan:
- Master 0 reads 0x0000_1000; slave answers 0xDEAD_BEEF after 3 cycles:
  - s_addr=0x1000, s_read=1 one cycle after request;
  - m0_data_ready pulses once with m0_rdata=0xDEADBEEF, m0_err=0;
  - m1 outputs stay 0.
- Both masters request continuously, slave with 1-cycle latency:
  - grants alternate 0,1,0,1 (first 0);
  - every transfer is separated by at least 1 IDLE cycle;
  - no master is granted twice in a row.
- Master 1 writes 0x0000_00AB to address 0x0000_0003 with wstrb=4'b1000 and wdata=0xAB00_0000, then deasserts m1_addr_ready mid-BUSY:
  - s_* stay latched (s_wstrb=4'b1000, s_wdata=0xAB000000) until s_data_ready;
  - m1_data_ready pulses once;
  - m1_rdata=0.
- Master 0 holds its request through its own completion cycle:
  - no regrant in the data_ready cycle;
  - regrant happens on the following cycle.
- rst pulsed low while BUSY:
  - all s_* and mi_* outputs go 0 immediately (before the next clk edge);
  - no data_ready is ever issued for that transfer;
  - master 0 wins the first grant after release.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave silent:
  - m0_data_ready=1 with m0_err=1, m0_rdata=0, 5 cycles after s_addr_ready rose;
  - s_data_ready arriving 2 cycles later is ignored.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter sharing one memory port, one transfer in flight.
// Optional busy-timeout abort is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_read,
    input  logic        m1_read,
    input  logic        m0_write,
    input  logic        m1_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m0_wstrb,
    input  logic [3:0]  m1_wstrb,
    input  logic        m0_addr_ready,
    input  logic        m1_addr_ready,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        m0_data_ready,
    output logic        m1_data_ready,
    output logic        m0_err,
    output logic        m1_err,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_addr_ready,
    input  logic [31:0] s_rdata,
    input  logic        s_data_ready
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    // A simultaneous read and write request is carried out as a write.
    function automatic req_t make_req(
        input logic              rd,
        input logic              wr,
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] d,
        input logic [STRB_W-1:0] s
    );
        req_t r;
        r.read  = rd & ~wr;
        r.write = wr;
        r.addr  = a;
        r.wdata = d;
        r.wstrb = s;
        return r;
    endfunction

    state_t                 state_q, state_d;
    logic                   last_q, last_d;
    logic                   owner_q, owner_d;
    req_t                   req_q, req_d;
    logic                   sar_q, sar_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]             dr_q, dr_d;
    logic [1:0]             err_q, err_d;
    logic [1:0]             elig;
    logic                   pick;
    logic                   abort;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Expiry only counts when the slave has not answered in the same cycle.
    assign abort = (state_q == BUSY) && !s_data_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign abort          = 1'b0;
`endif

    // A master whose completion pulse is showing this cycle is not eligible.
    assign elig = {m1_addr_ready & (m1_read | m1_write) & ~dr_q[1],
                   m0_addr_ready & (m0_read | m0_write) & ~dr_q[0]};

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        req_d   = req_q;
        sar_d   = sar_q;
        rdata_d = rdata_q;
        dr_d    = 2'b00;
        err_d   = 2'b00;
        pick    = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (elig != 2'b00) begin
                    pick    = (elig == 2'b11) ? ~last_q : elig[1];
                    owner_d = pick;
                    last_d  = pick;
                    req_d   = pick ? make_req(m1_read, m1_write, m1_addr, m1_wdata, m1_wstrb)
                                   : make_req(m0_read, m0_write, m0_addr, m0_wdata, m0_wstrb);
                    sar_d   = 1'b1;
                    state_d = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                if (s_data_ready || abort) begin
                    rdata_d[owner_q] = (s_data_ready && req_q.read) ? s_rdata : '0;
                    dr_d[owner_q]    = 1'b1;
                    err_d[owner_q]   = abort;
                    req_d.read       = 1'b0;
                    req_d.write      = 1'b0;
                    sar_d            = 1'b0;
                    state_d          = IDLE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            req_q   <= '0;
            sar_q   <= 1'b0;
            rdata_q <= '0;
            dr_q    <= 2'b00;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            req_q   <= req_d;
            sar_q   <= sar_d;
            rdata_q <= rdata_d;
            dr_q    <= dr_d;
            err_q   <= err_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign s_read        = req_q.read;
    assign s_write       = req_q.write;
    assign s_addr        = req_q.addr;
    assign s_wdata       = req_q.wdata;
    assign s_wstrb       = req_q.wstrb;
    assign s_addr_ready  = sar_q;
    assign m0_rdata      = rdata_q[0];
    assign m1_rdata      = rdata_q[1];
    assign m0_data_ready = dr_q[0];
    assign m1_data_ready = dr_q[1];
    assign m0_err        = err_q[0];
    assign m1_err        = err_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed multi-cycle sequences and a random run against a
// transaction-level reference model of the arbiter.
module tb_mem_arbiter;
    localparam int unsigned TO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic        s_read;
        logic        s_write;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic [3:0]  s_wstrb;
        logic        s_addr_ready;
        logic [31:0] m0_rdata;
        logic        m0_data_ready;
        logic        m0_err;
        logic [31:0] m1_rdata;
        logic        m1_data_ready;
        logic        m1_err;
    } out_t;

    typedef struct {
        logic [1:0]  req;      // bit i: master i addr_ready
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        sdr;
        logic [31:0] srdata;
        logic [2:0]  e_sctl;   // {s_addr_ready, s_read, s_write}
        logic [31:0] e_saddr;
        logic [1:0]  e_dr;     // {m1, m0} data_ready
        logic [31:0] e_m0rd;
        logic [31:0] e_m1rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ar, rd, wr;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_data_ready, m1_data_ready, m0_err, m1_err;
    logic        s_read, s_write, s_addr_ready;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata;
    logic        s_data_ready;

    int n_vec  = 0;
    int n_miss = 0;

    // reference model: the transfer in flight and what each master last received
    logic        mdl_v;
    int          mdl_owner, mdl_last, mdl_age;
    logic        mdl_rd, mdl_wr;
    logic [31:0] mdl_addr, mdl_wdata;
    logic [3:0]  mdl_wstrb;
    logic [31:0] mdl_rdata [2];
    logic [1:0]  mdl_pulse, mdl_err;

    vec_t tbl [18];
    out_t exp;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_read(rd[0]), .m1_read(rd[1]),
        .m0_write(wr[0]), .m1_write(wr[1]),
        .m0_addr(addr[0]), .m1_addr(addr[1]),
        .m0_wdata(wdata[0]), .m1_wdata(wdata[1]),
        .m0_wstrb(wstrb[0]), .m1_wstrb(wstrb[1]),
        .m0_addr_ready(ar[0]), .m1_addr_ready(ar[1]),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_data_ready(m0_data_ready), .m1_data_ready(m1_data_ready),
        .m0_err(m0_err), .m1_err(m1_err),
        .s_read(s_read), .s_write(s_write), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_addr_ready(s_addr_ready),
        .s_rdata(s_rdata), .s_data_ready(s_data_ready)
    );

    function automatic out_t sample();
        out_t o;
        o.s_read        = s_read;
        o.s_write       = s_write;
        o.s_addr        = s_addr;
        o.s_wdata       = s_wdata;
        o.s_wstrb       = s_wstrb;
        o.s_addr_ready  = s_addr_ready;
        o.m0_rdata      = m0_rdata;
        o.m0_data_ready = m0_data_ready;
        o.m0_err        = m0_err;
        o.m1_rdata      = m1_rdata;
        o.m1_data_ready = m1_data_ready;
        o.m1_err        = m1_err;
        return o;
    endfunction

    function automatic out_t row_exp(input vec_t v);
        out_t o;
        o               = '0;
        o.s_addr_ready  = v.e_sctl[2];
        o.s_read        = v.e_sctl[1];
        o.s_write       = v.e_sctl[0];
        o.s_addr        = v.e_saddr;
        o.m0_data_ready = v.e_dr[0];
        o.m1_data_ready = v.e_dr[1];
        o.m0_rdata      = v.e_m0rd;
        o.m1_rdata      = v.e_m1rd;
        return o;
    endfunction

    function automatic out_t mdl_out();
        out_t o;
        o.s_read        = mdl_v & mdl_rd;
        o.s_write       = mdl_v & mdl_wr;
        o.s_addr        = mdl_addr;
        o.s_wdata       = mdl_wdata;
        o.s_wstrb       = mdl_wstrb;
        o.s_addr_ready  = mdl_v;
        o.m0_rdata      = mdl_rdata[0];
        o.m0_data_ready = mdl_pulse[0];
        o.m0_err        = mdl_err[0];
        o.m1_rdata      = mdl_rdata[1];
        o.m1_data_ready = mdl_pulse[1];
        o.m1_err        = mdl_err[1];
        return o;
    endfunction

    task automatic check(input string name, input out_t act, input out_t want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mdl_v        = 1'b0;
        mdl_owner    = 0;
        mdl_last     = 1;
        mdl_age      = 0;
        mdl_rd       = 1'b0;
        mdl_wr       = 1'b0;
        mdl_addr     = '0;
        mdl_wdata    = '0;
        mdl_wstrb    = '0;
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        mdl_pulse    = 2'b00;
        mdl_err      = 2'b00;
    endtask

    // One clock edge of the arbitration rules, applied to the inputs seen at that edge.
    task automatic model_edge();
        logic [1:0] el, pulse_n, err_n;
        pulse_n = 2'b00;
        err_n   = 2'b00;
        el      = ar & (rd | wr) & ~mdl_pulse;
        if (!mdl_v) begin
            if (el != 2'b00) begin
                int g;
                g         = (el == 2'b11) ? 1 - mdl_last : (el[1] ? 1 : 0);
                mdl_v     = 1'b1;
                mdl_owner = g;
                mdl_last  = g;
                mdl_age   = 0;
                mdl_wr    = wr[g];
                mdl_rd    = rd[g] & ~wr[g];
                mdl_addr  = addr[g];
                mdl_wdata = wdata[g];
                mdl_wstrb = wstrb[g];
            end
        end else if (s_data_ready) begin
            mdl_rdata[mdl_owner] = mdl_rd ? s_rdata : 32'h0;
            pulse_n[mdl_owner]   = 1'b1;
            mdl_v                = 1'b0;
        end else if (TO_EN && mdl_age == int'(TO)) begin
            mdl_rdata[mdl_owner] = 32'h0;
            pulse_n[mdl_owner]   = 1'b1;
            err_n[mdl_owner]     = 1'b1;
            mdl_v                = 1'b0;
        end else begin
            mdl_age++;
        end
        mdl_pulse = pulse_n;
        mdl_err   = err_n;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // req, rd, wr, sdr, srdata | {sar,srd,swr}, s_addr, {m1,m0} dr, m0_rdata, m1_rdata
        tbl[0]  = '{2'b01, 2'b01, 2'b00, 1'b0, 32'h0,         3'b110, 32'h1000, 2'b00, 32'h0,         32'h0};
        tbl[1]  = '{2'b01, 2'b01, 2'b00, 1'b0, 32'h0,         3'b110, 32'h1000, 2'b00, 32'h0,         32'h0};
        tbl[2]  = '{2'b01, 2'b01, 2'b00, 1'b0, 32'h0,         3'b110, 32'h1000, 2'b00, 32'h0,         32'h0};
        tbl[3]  = '{2'b01, 2'b01, 2'b00, 1'b1, 32'hDEADBEEF,  3'b000, 32'h1000, 2'b01, 32'hDEADBEEF,  32'h0};
        tbl[4]  = '{2'b01, 2'b01, 2'b00, 1'b0, 32'h0,         3'b000, 32'h1000, 2'b00, 32'hDEADBEEF,  32'h0};
        tbl[5]  = '{2'b01, 2'b01, 2'b00, 1'b0, 32'h0,         3'b110, 32'h1000, 2'b00, 32'hDEADBEEF,  32'h0};
        tbl[6]  = '{2'b01, 2'b01, 2'b00, 1'b1, 32'h0BADF00D,  3'b000, 32'h1000, 2'b01, 32'h0BADF00D,  32'h0};
        tbl[7]  = '{2'b00, 2'b00, 2'b00, 1'b0, 32'h0,         3'b000, 32'h1000, 2'b00, 32'h0BADF00D,  32'h0};
        tbl[8]  = '{2'b11, 2'b11, 2'b00, 1'b0, 32'h0,         3'b110, 32'h0200, 2'b00, 32'h0BADF00D,  32'h0};
        tbl[9]  = '{2'b11, 2'b11, 2'b00, 1'b1, 32'hB0B00002,  3'b000, 32'h0200, 2'b10, 32'h0BADF00D,  32'hB0B00002};
        tbl[10] = '{2'b11, 2'b11, 2'b00, 1'b0, 32'h0,         3'b110, 32'h1000, 2'b00, 32'h0BADF00D,  32'hB0B00002};
        tbl[11] = '{2'b11, 2'b11, 2'b00, 1'b1, 32'hC0C00003,  3'b000, 32'h1000, 2'b01, 32'hC0C00003,  32'hB0B00002};
        tbl[12] = '{2'b11, 2'b11, 2'b00, 1'b0, 32'h0,         3'b110, 32'h0200, 2'b00, 32'hC0C00003,  32'hB0B00002};
        tbl[13] = '{2'b11, 2'b11, 2'b00, 1'b1, 32'hD0D00004,  3'b000, 32'h0200, 2'b10, 32'hC0C00003,  32'hD0D00004};
        tbl[14] = '{2'b11, 2'b11, 2'b01, 1'b0, 32'h0,         3'b101, 32'h1000, 2'b00, 32'hC0C00003,  32'hD0D00004};
        tbl[15] = '{2'b11, 2'b11, 2'b01, 1'b1, 32'hEEEEEEEE,  3'b000, 32'h1000, 2'b01, 32'h0,         32'hD0D00004};
        tbl[16] = '{2'b00, 2'b00, 2'b00, 1'b1, 32'hFFFFFFFF,  3'b000, 32'h1000, 2'b00, 32'h0,         32'hD0D00004};
        tbl[17] = '{2'b00, 2'b00, 2'b00, 1'b0, 32'h0,         3'b000, 32'h1000, 2'b00, 32'h0,         32'hD0D00004};

        rst          = 1'b0;
        ar           = 2'b00;
        rd           = 2'b00;
        wr           = 2'b00;
        addr[0]      = 32'h1000;
        addr[1]      = 32'h0200;
        wdata[0]     = '0;
        wdata[1]     = '0;
        wstrb[0]     = '0;
        wstrb[1]     = '0;
        s_rdata      = '0;
        s_data_ready = 1'b0;
        repeat (2) tick();
        check("reset", sample(), '0);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            ar           = tbl[i].req;
            rd           = tbl[i].rd;
            wr           = tbl[i].wr;
            s_data_ready = tbl[i].sdr;
            s_rdata      = tbl[i].srdata;
            tick();
            check($sformatf("table[%0d]", i), sample(), row_exp(tbl[i]));
        end
        exp = row_exp(tbl[17]);

        // master 1 byte write, request withdrawn while the transfer is in flight
        ar       = 2'b10;
        rd       = 2'b00;
        wr       = 2'b10;
        addr[1]  = 32'h0000_0003;
        wdata[1] = 32'hAB00_0000;
        wstrb[1] = 4'b1000;
        tick();
        exp.s_read       = 1'b0;
        exp.s_write      = 1'b1;
        exp.s_addr       = 32'h0000_0003;
        exp.s_wdata      = 32'hAB00_0000;
        exp.s_wstrb      = 4'b1000;
        exp.s_addr_ready = 1'b1;
        check("wr_grant", sample(), exp);
        ar       = 2'b00;
        wr       = 2'b00;
        addr[1]  = 32'hFFFF_FFFC;
        wdata[1] = 32'h5555_5555;
        wstrb[1] = 4'hF;
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("wr_hold[%0d]", k), sample(), exp);
        end
        s_data_ready = 1'b1;
        s_rdata      = 32'h1234_5678;
        tick();
        exp.s_write       = 1'b0;
        exp.s_addr_ready  = 1'b0;
        exp.m1_data_ready = 1'b1;
        exp.m1_rdata      = 32'h0;
        check("wr_done", sample(), exp);
        s_data_ready = 1'b0;
        tick();
        exp.m1_data_ready = 1'b0;
        check("wr_pulse_end", sample(), exp);

        // asynchronous reset during a master 0 read
        ar      = 2'b01;
        rd      = 2'b01;
        addr[0] = 32'h0000_0040;
        addr[1] = 32'h0000_0080;
        tick();
        exp.s_read       = 1'b1;
        exp.s_addr       = 32'h0000_0040;
        exp.s_wdata      = 32'h0;
        exp.s_wstrb      = 4'h0;
        exp.s_addr_ready = 1'b1;
        check("rst_busy_pre", sample(), exp);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async", sample(), '0);
        s_data_ready = 1'b1;
        s_rdata      = 32'hCAFE_0001;
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("rst_hold[%0d]", k), sample(), '0);
        end
        s_data_ready = 1'b0;
        ar           = 2'b11;
        rd           = 2'b11;
        #3;
        rst = 1'b1;
        tick();
        exp              = '0;
        exp.s_read       = 1'b1;
        exp.s_addr       = 32'h0000_0040;
        exp.s_addr_ready = 1'b1;
        check("rst_first_grant", sample(), exp);
        s_data_ready = 1'b1;
        s_rdata      = 32'h5A5A_5A5A;
        tick();
        exp.s_read        = 1'b0;
        exp.s_addr_ready  = 1'b0;
        exp.m0_data_ready = 1'b1;
        exp.m0_rdata      = 32'h5A5A_5A5A;
        check("rst_after_done", sample(), exp);
        s_data_ready = 1'b0;
        ar           = 2'b00;
        tick();
        exp.m0_data_ready = 1'b0;
        check("rst_after_idle", sample(), exp);

`ifdef MEM_ARB_TIMEOUT_EN
        // silent slave: abort after TO busy cycles, late answer ignored
        ar      = 2'b01;
        rd      = 2'b01;
        addr[0] = 32'h0000_0500;
        tick();
        exp.s_read       = 1'b1;
        exp.s_addr       = 32'h0000_0500;
        exp.s_addr_ready = 1'b1;
        check("to_grant", sample(), exp);
        ar = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("to_wait[%0d]", k), sample(), exp);
        end
        tick();
        exp.s_read        = 1'b0;
        exp.s_addr_ready  = 1'b0;
        exp.m0_data_ready = 1'b1;
        exp.m0_err        = 1'b1;
        exp.m0_rdata      = 32'h0;
        check("to_abort", sample(), exp);
        tick();
        exp.m0_data_ready = 1'b0;
        exp.m0_err        = 1'b0;
        check("to_after", sample(), exp);
        s_data_ready = 1'b1;
        s_rdata      = 32'h7777_7777;
        tick();
        check("to_late_ignored", sample(), exp);
        s_data_ready = 1'b0;
`endif

        // random traffic against the reference model, from a fresh reset
        ar           = 2'b00;
        rd           = 2'b00;
        wr           = 2'b00;
        s_data_ready = 1'b0;
        rst          = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                ar[i]    = ($urandom_range(0, 2) != 0);
                rd[i]    = 1'($urandom_range(0, 1));
                wr[i]    = 1'($urandom_range(0, 1));
                addr[i]  = $urandom();
                wdata[i] = $urandom();
                wstrb[i] = 4'($urandom());
            end
            s_data_ready = ($urandom_range(0, 2) == 0);
            s_rdata      = $urandom();
            @(posedge clk);
            model_edge();
            #1;
            check($sformatf("random[%0d]", c), sample(), mdl_out());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
